// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and picks each cycle's fetch address.
// Handles the boot vector load, sequential fetch, two-word instructions, jump
// redirect and interrupt entry. The instruction memory reads combinationally,
// so mem_addr_o is the registered PC.
module fetch_sequencer #(
  parameter int AW           = 32,
  parameter int IMM_BIT      = 0,
  parameter int BOOT_ADDR    = 0,
  parameter int INT_VEC_ADDR = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          jump_i,
  input  logic [AW-1:0] jump_tgt_i,
  input  logic          int_req_i,
  input  logic [15:0]   instr_i,
  output logic [AW-1:0] mem_addr_o,
  output logic [15:0]   instr_o,
  output logic          instr_vld_o,
  output logic [15:0]   imm_o,
  output logic          imm_vld_o,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] ret_pc_o,
  output logic          int_ack_o,
  output logic          flush_o
);

  typedef enum logic [2:0] {
    S_BOOT_HI = 3'd0,
    S_BOOT_LO = 3'd1,
    S_RUN     = 3'd2,
    S_IMM     = 3'd3,
    S_VEC_HI  = 3'd4,
    S_VEC_LO  = 3'd5
  } state_t;

  localparam logic [AW-1:0] BOOT_A = AW'(BOOT_ADDR);
  localparam logic [AW-1:0] VEC_A  = AW'(INT_VEC_ADDR);
  localparam logic [AW-1:0] BOOT_N = BOOT_A + AW'(1);
  localparam logic [AW-1:0] VEC_N  = VEC_A + AW'(1);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_next;
  logic [AW-1:0] r_ret_pc;
  logic [AW-1:0] w_ret_next;
  logic [AW-1:0] w_pc_inc;
  logic          w_instr_vld;
  logic          w_imm_vld;
  logic          w_int_ack;
  logic          w_flush;

  // High vector word goes to the upper PC bits; the low half points at the next vector word.
  function automatic logic [AW-1:0] load_hi(input logic [15:0] hi, input logic [AW-1:0] nxt);
    logic [AW-1:0] v;
    v          = '0;
    v[AW-1:16] = hi[AW-17:0];
    v[15:0]    = nxt[15:0];
    return v;
  endfunction

  assign w_pc_inc = r_pc + AW'(1);

  // Next-state, next-PC and per-cycle control outputs
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ret_next   = r_ret_pc;
    w_instr_vld  = 1'b0;
    w_imm_vld    = 1'b0;
    w_int_ack    = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      S_BOOT_HI: begin
        w_pc_next    = load_hi(instr_i, BOOT_N);
        w_state_next = S_BOOT_LO;
      end
      S_BOOT_LO: begin
        w_pc_next    = {r_pc[AW-1:16], instr_i};
        w_state_next = S_RUN;
      end
      S_VEC_HI: begin
        w_pc_next    = load_hi(instr_i, VEC_N);
        w_state_next = S_VEC_LO;
      end
      S_VEC_LO: begin
        w_pc_next    = {r_pc[AW-1:16], instr_i};
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (jump_i) begin
          w_pc_next = jump_tgt_i;
          w_flush   = 1'b1;
        end else if (stall_i) begin
          w_instr_vld = 1'b1;
        end else if (int_req_i) begin
          // The word at pc is discarded and re-fetched on return.
          w_ret_next   = r_pc;
          w_int_ack    = 1'b1;
          w_flush      = 1'b1;
          w_pc_next    = VEC_A;
          w_state_next = S_VEC_HI;
        end else begin
          w_instr_vld = 1'b1;
          w_pc_next   = w_pc_inc;
          if (instr_i[IMM_BIT]) w_state_next = S_IMM;
        end
      end
      S_IMM: begin
        if (jump_i) begin
          w_pc_next    = jump_tgt_i;
          w_flush      = 1'b1;
          w_state_next = S_RUN;
        end else if (stall_i) begin
          w_imm_vld = 1'b1;
        end else begin
          w_imm_vld    = 1'b1;
          w_pc_next    = w_pc_inc;
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_pc_next    = BOOT_A;
        w_state_next = S_BOOT_HI;
      end
    endcase
  end

  // State, PC and return-PC registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_BOOT_HI;
      r_pc     <= BOOT_A;
      r_ret_pc <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_ret_pc <= w_ret_next;
    end
  end

  assign mem_addr_o  = r_pc;
  assign pc_o        = r_pc;
  assign ret_pc_o    = r_ret_pc;
  assign instr_o     = instr_i;
  assign imm_o       = (r_state == S_IMM) ? instr_i : 16'h0000;
  assign instr_vld_o = w_instr_vld;
  assign imm_vld_o   = w_imm_vld;
  assign int_ack_o   = w_int_ack;
  assign flush_o     = w_flush;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven directed vectors for fetch_sequencer with a
// small combinational instruction memory, plus hand-written reset sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_tgt_i;
  logic        int_req_i;
  logic [15:0] instr_i;
  logic [31:0] mem_addr_o;
  logic [15:0] instr_o;
  logic        instr_vld_o;
  logic [15:0] imm_o;
  logic        imm_vld_o;
  logic [31:0] pc_o;
  logic [31:0] ret_pc_o;
  logic        int_ack_o;
  logic        flush_o;

  logic [15:0] mem [0:1023];

  int n_chk;
  int n_err;

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] tgt;
    logic        irq;
    logic [31:0] pc;
    logic        vld;
    logic        ivld;
    logic [15:0] imm;
    logic        fl;
    logic        ack;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  fetch_sequencer #(.AW(32), .IMM_BIT(0), .BOOT_ADDR(0), .INT_VEC_ADDR(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i), .jump_tgt_i(jump_tgt_i),
    .int_req_i(int_req_i), .instr_i(instr_i), .mem_addr_o(mem_addr_o), .instr_o(instr_o),
    .instr_vld_o(instr_vld_o), .imm_o(imm_o), .imm_vld_o(imm_vld_o), .pc_o(pc_o),
    .ret_pc_o(ret_pc_o), .int_ack_o(int_ack_o), .flush_o(flush_o)
  );

  assign instr_i = mem[mem_addr_o[9:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic row(input logic s, input logic j, input logic [31:0] t, input logic q,
                     input logic [31:0] pc, input logic v, input logic iv,
                     input logic [15:0] im, input logic f, input logic a,
                     input logic [31:0] r);
    vec_t x;
    x.stall = s; x.jump = j; x.tgt = t; x.irq = q;
    x.pc = pc; x.vld = v; x.ivld = iv; x.imm = im; x.fl = f; x.ack = a; x.ret = r;
    vecs.push_back(x);
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_ret);
    chk({tag, "_pc"}, pc_o, exp_pc);
    chk({tag, "_addr"}, mem_addr_o, exp_pc);
    chk({tag, "_vld"}, {31'b0, instr_vld_o}, 32'h0);
    chk({tag, "_ivld"}, {31'b0, imm_vld_o}, 32'h0);
    chk({tag, "_flush"}, {31'b0, flush_o}, 32'h0);
    chk({tag, "_ack"}, {31'b0, int_ack_o}, 32'h0);
    chk({tag, "_ret"}, ret_pc_o, exp_ret);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[16'h000] = 16'h0000; mem[16'h001] = 16'h0040;
    mem[16'h002] = 16'h0000; mem[16'h003] = 16'h0200;
    mem[16'h040] = 16'h1000; mem[16'h041] = 16'h2000;
    mem[16'h042] = 16'h3001; mem[16'h043] = 16'hBEEF;
    mem[16'h044] = 16'h4000; mem[16'h045] = 16'h5000;
    mem[16'h046] = 16'h6001; mem[16'h047] = 16'h1234;
    mem[16'h048] = 16'h7000; mem[16'h049] = 16'h7100;
    mem[16'h100] = 16'h8000; mem[16'h101] = 16'h9000;
    mem[16'h200] = 16'hA000; mem[16'h201] = 16'hB000;

    //   stall jump tgt           irq  pc            vld ivld imm       fl ack ret
    row(0, 0, 32'h0,        0, 32'h0,        0, 0, 16'h0,    0, 0, 32'h0);   // BOOT_HI
    row(0, 0, 32'h0,        0, 32'h1,        0, 0, 16'h0,    0, 0, 32'h0);   // BOOT_LO
    row(0, 0, 32'h0,        0, 32'h40,       1, 0, 16'h0,    0, 0, 32'h0);   // first fetch
    row(1, 0, 32'h0,        0, 32'h41,       1, 0, 16'h0,    0, 0, 32'h0);   // stall 1
    row(1, 0, 32'h0,        0, 32'h41,       1, 0, 16'h0,    0, 0, 32'h0);   // stall 2
    row(1, 0, 32'h0,        1, 32'h41,       1, 0, 16'h0,    0, 0, 32'h0);   // stall beats irq
    row(0, 0, 32'h0,        0, 32'h41,       1, 0, 16'h0,    0, 0, 32'h0);
    row(0, 0, 32'h0,        0, 32'h42,       1, 0, 16'h0,    0, 0, 32'h0);   // two-word instr
    row(1, 0, 32'h0,        1, 32'h43,       0, 1, 16'hBEEF, 0, 0, 32'h0);   // IMM stall, irq ignored
    row(0, 0, 32'h0,        0, 32'h43,       0, 1, 16'hBEEF, 0, 0, 32'h0);   // IMM
    row(0, 1, 32'h45,       1, 32'h44,       0, 0, 16'h0,    1, 0, 32'h0);   // jump beats irq
    row(0, 0, 32'h0,        1, 32'h45,       0, 0, 16'h0,    1, 1, 32'h0);   // irq accepted
    row(1, 1, 32'h999,      0, 32'h2,        0, 0, 16'h0,    0, 0, 32'h45);  // VEC_HI ignores
    row(0, 0, 32'h0,        0, 32'h3,        0, 0, 16'h0,    0, 0, 32'h45);  // VEC_LO
    row(0, 0, 32'h0,        0, 32'h200,      1, 0, 16'h0,    0, 0, 32'h45);  // ISR fetch
    row(1, 1, 32'h100,      0, 32'h201,      0, 0, 16'h0,    1, 0, 32'h45);  // jump beats stall
    row(0, 0, 32'h0,        0, 32'h100,      1, 0, 16'h0,    0, 0, 32'h45);
    row(0, 1, 32'hFFFFFFFF, 0, 32'h101,      0, 0, 16'h0,    1, 0, 32'h45);
    row(0, 0, 32'h0,        0, 32'hFFFFFFFF, 1, 0, 16'h0,    0, 0, 32'h45);  // wrap point
    row(0, 0, 32'h0,        0, 32'h0,        1, 0, 16'h0,    0, 0, 32'h45);  // wrapped to 0
    row(0, 1, 32'h46,       0, 32'h1,        0, 0, 16'h0,    1, 0, 32'h45);
    row(0, 0, 32'h0,        0, 32'h46,       1, 0, 16'h0,    0, 0, 32'h45);
    row(0, 1, 32'h48,       0, 32'h47,       0, 0, 16'h0,    1, 0, 32'h45);  // jump drops imm
    row(0, 0, 32'h0,        0, 32'h48,       1, 0, 16'h0,    0, 0, 32'h45);
    row(0, 1, 32'h42,       0, 32'h49,       0, 0, 16'h0,    1, 0, 32'h45);
    row(0, 0, 32'h0,        0, 32'h42,       1, 0, 16'h0,    0, 0, 32'h45);
    row(0, 0, 32'h0,        0, 32'h43,       0, 1, 16'hBEEF, 0, 0, 32'h45);  // IMM, reset follows

    rst = 1'b0; stall_i = 1'b0; jump_i = 1'b0; jump_tgt_i = '0; int_req_i = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk_idle("reset", 32'h0, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    foreach (vecs[i]) begin
      stall_i = vecs[i].stall; jump_i = vecs[i].jump;
      jump_tgt_i = vecs[i].tgt; int_req_i = vecs[i].irq;
      #2;
      chk($sformatf("v%0d_pc", i), pc_o, vecs[i].pc);
      chk($sformatf("v%0d_addr", i), mem_addr_o, vecs[i].pc);
      chk($sformatf("v%0d_instr", i), {16'h0, instr_o}, {16'h0, mem[vecs[i].pc[9:0]]});
      chk($sformatf("v%0d_vld", i), {31'b0, instr_vld_o}, {31'b0, vecs[i].vld});
      chk($sformatf("v%0d_ivld", i), {31'b0, imm_vld_o}, {31'b0, vecs[i].ivld});
      if (vecs[i].ivld) chk($sformatf("v%0d_imm", i), {16'h0, imm_o}, {16'h0, vecs[i].imm});
      chk($sformatf("v%0d_flush", i), {31'b0, flush_o}, {31'b0, vecs[i].fl});
      chk($sformatf("v%0d_ack", i), {31'b0, int_ack_o}, {31'b0, vecs[i].ack});
      chk($sformatf("v%0d_ret", i), ret_pc_o, vecs[i].ret);
      if (i != vecs.size() - 1) @(negedge clk);
    end

    // Reset asserted mid-IMM, between clock edges: outputs clear without a clock.
    #1;
    rst = 1'b0;
    stall_i = 1'b0; jump_i = 1'b0; int_req_i = 1'b0;
    #1;
    chk_idle("midrst", 32'h0, 32'h0);
    chk("midrst_imm", {16'h0, imm_o}, 32'h0);
    mem[1] = 16'h0048;
    repeat (2) @(negedge clk);
    #2;
    chk_idle("rsthold", 32'h0, 32'h0);

    // Reboot reloads the vector from memory.
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk_idle("reboot0", 32'h0, 32'h0);
    @(negedge clk);
    #2;
    chk_idle("reboot1", 32'h1, 32'h0);
    @(negedge clk);
    #2;
    chk("reboot2_pc", pc_o, 32'h48);
    chk("reboot2_vld", {31'b0, instr_vld_o}, 32'h1);
    chk("reboot2_instr", {16'h0, instr_o}, 32'h7000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
